prog_counter_4bit: RTL and testbench

Programmable-step 8-bit counter for the Zybo Z7 switch/LED demo. It sits between the board switches and the LED/display outputs. A clock divider produces a slow visible clock `clock_out` and an internal count tick. On each tick the counter advances by the 4-bit step set on the switches. Everything runs in the single `clock` domain; `clock_out` is an output only and never clocks internal logic.

---
 rtl/prog_counter_pkg.sv | 16 +
 rtl/prog_counter_clk_div_tick.sv | 44 ++++
 rtl/prog_counter_4bit.sv | 75 +++++++
 tb/tb_prog_counter_4bit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// +------------------------------------------------------------------+
// | prog_counter_pkg : widths, defaults and types for prog_counter_4bit |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package prog_counter_pkg;
  localparam int COUNT_W          = 8;
  localparam int STEP_W           = 4;
  localparam int DIV_HALF_DEFAULT = 2;

  typedef logic [COUNT_W-1:0] count_t;
  typedef logic [STEP_W-1:0]  step_t;
endpackage

`default_nettype wire

// File: rtl/prog_counter_clk_div_tick.sv
// +------------------------------------------------------------------+
// | clk_div_tick : 50% divided clock_out plus a tick on its 0->1 edge  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module clk_div_tick #(
  parameter int DIV_HALF = 2
) (
  input  logic clock,
  input  logic rst_n_sync,
  output logic clock_out,
  output logic tick
);
  // A single-bit counter keeps DIV_HALF=1 legal (it simply wraps every cycle).
  localparam int              CNT_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_HALF - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             wrap;

  assign wrap = (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = wrap ? '0 : div_cnt_q + CNT_W'(1);
    clk_out_d = clk_out_q ^ wrap;
  end

  always_ff @(posedge clock or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      div_cnt_q <= '0;
      clk_out_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clock_out = clk_out_q;
  assign tick      = wrap & ~clk_out_q;
endmodule

`default_nettype wire

// File: rtl/prog_counter_4bit.sv
// +------------------------------------------------------------------+
// | prog_counter_4bit : 8-bit counter advancing by a switch step per   |
// | divided tick. Macro PROG_COUNTER_SATURATE_EN clamps at 255.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module prog_counter_4bit
  import prog_counter_pkg::*;
#(
  parameter int DIV_HALF = DIV_HALF_DEFAULT
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [STEP_W-1:0]  sw_in,
  output logic               clock_out,
  output logic [COUNT_W-1:0] cout
);
  logic [1:0] rst_sync_q;
  logic       rst_n_sync;
  step_t      sw_meta_q, step_q;
  logic       tick;
  count_t     cout_q, cout_d;

  // Assertion is asynchronous, release is two clocks later.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_sync = rst_sync_q[1];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sw_meta_q <= '0;
      step_q    <= '0;
    end else begin
      sw_meta_q <= sw_in;
      step_q    <= sw_meta_q;
    end
  end

  clk_div_tick #(
    .DIV_HALF (DIV_HALF)
  ) u_clk_div_tick (
    .clock      (clock),
    .rst_n_sync (rst_n_sync),
    .clock_out  (clock_out),
    .tick       (tick)
  );

`ifdef PROG_COUNTER_SATURATE_EN
  logic [COUNT_W:0] sum;

  always_comb begin
    sum    = {1'b0, cout_q} + {{(COUNT_W + 1 - STEP_W){1'b0}}, step_q};
    cout_d = cout_q;
    if (tick) cout_d = sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];
  end
`else
  always_comb begin
    cout_d = cout_q;
    if (tick) cout_d = cout_q + {{(COUNT_W - STEP_W){1'b0}}, step_q};
  end
`endif

  always_ff @(posedge clock or negedge rst_n_sync) begin
    if (!rst_n_sync) cout_q <= '0;
    else             cout_q <= cout_d;
  end

  assign cout = cout_q;
endmodule

`default_nettype wire

// File: tb/tb_prog_counter_4bit.sv
// +------------------------------------------------------------------+
// | tb_prog_counter_4bit : self-checking bench, DIV_HALF=2 and =5 DUTs |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_prog_counter_4bit;
  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic [3:0] sw_in = 4'd0;
  logic       co_a, co_b;
  logic [7:0] cout_a, cout_b;

  int n_checks = 0;
  int n_fail   = 0;

  prog_counter_4bit #(.DIV_HALF(2)) dut_a (
    .clock(clock), .rst(rst), .sw_in(sw_in), .clock_out(co_a), .cout(cout_a)
  );
  prog_counter_4bit #(.DIV_HALF(5)) dut_b (
    .clock(clock), .rst(rst), .sw_in(sw_in), .clock_out(co_b), .cout(cout_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: everything derived from the number of clock edges
  // seen with rst high and the switch value sampled two edges earlier.
  int dh[2]       = '{2, 5};
  int rst_hi      = 0;
  int exp_cout[2] = '{0, 0};
  int exp_co[2]   = '{0, 0};
  int ticks[2]    = '{0, 0};
  int sw_d1       = 0;
  int sw_d2       = 0;

  always @(negedge rst) begin
    rst_hi   = 0;
    exp_cout = '{0, 0};
    exp_co   = '{0, 0};
    sw_d1    = 0;
    sw_d2    = 0;
  end

  always @(posedge clock) begin
    int t;
    if (!rst) begin
      rst_hi   = 0;
      exp_cout = '{0, 0};
      exp_co   = '{0, 0};
      sw_d1    = 0;
      sw_d2    = 0;
    end else begin
      rst_hi++;
      t = rst_hi - 2;
      for (int i = 0; i < 2; i++) begin
        if (t > 0) begin
          exp_co[i] = (t / dh[i]) % 2;
          if (t % (2 * dh[i]) == dh[i]) begin
            ticks[i]++;
            exp_cout[i] = exp_cout[i] + sw_d2;
`ifdef PROG_COUNTER_SATURATE_EN
            if (exp_cout[i] > 255) exp_cout[i] = 255;
`else
            if (exp_cout[i] > 255) exp_cout[i] = exp_cout[i] - 256;
`endif
          end
        end
      end
      sw_d2 = sw_d1;
      sw_d1 = int'(sw_in);
    end
  end

  always @(posedge clock) begin
    #1;
    check("cout_div2",   cout_a, exp_cout[0]);
    check("clkout_div2", co_a,   exp_co[0]);
    check("cout_div5",   cout_b, exp_cout[1]);
    check("clkout_div5", co_b,   exp_co[1]);
  end

  task automatic wait_ticks(input int idx, input int n, input int budget);
    int  target;
    bit  ok;
    target = ticks[idx] + n;
    ok     = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clock);
      #2;
      if (ticks[idx] >= target) ok = 1'b1;
    end
    check("tick_wait_timeout", ticks[idx], target);
  endtask

  initial begin
    int   highs, rises, updates, unaligned;
    logic prev_co;
    logic [7:0] prev_cout;

    // Reset held with a non-zero step: nothing moves.
    rst   = 1'b0;
    sw_in = 4'd3;
    repeat (5) @(posedge clock);
    #2;
    check("reset_cout",   cout_a, 0);
    check("reset_clkout", co_a,   0);
    check("reset_cout5",  cout_b, 0);

    // Basic step of 3.
    @(negedge clock) rst = 1'b1;
    wait_ticks(0, 1, 20);
    check("first_tick_cout",   cout_a, 3);
    check("first_tick_clkout", co_a,   1);
    wait_ticks(0, 2, 20);
    check("third_tick_cout", cout_a, 9);

    // Asynchronous reset between edges while cout=9.
    #1 rst = 1'b0;
    #1;
    check("async_rst_cout",    cout_a, 0);
    check("async_rst_clkout",  co_a,   0);
    check("async_rst_cout5",   cout_b, 0);
    check("async_rst_clkout5", co_b,   0);

    // Restart with step 0: count holds.
    @(negedge clock) begin rst = 1'b1; sw_in = 4'd0; end
    wait_ticks(0, 3, 40);
    check("hold_cout", cout_a, 0);

    // Switch to 5 half a cycle before a tick: that tick still adds 0.
    repeat (4) @(negedge clock);
    sw_in = 4'd5;
    wait_ticks(0, 1, 20);
    check("latency_old_step", cout_a, 0);
    wait_ticks(0, 1, 20);
    check("latency_new_step", cout_a, 5);

    // Wrap / saturate with step 15 from reset.
    @(negedge clock) begin rst = 1'b0; sw_in = 4'd15; end
    repeat (2) @(negedge clock);
    rst = 1'b1;
    wait_ticks(0, 17, 200);
    check("tick17_cout", cout_a, 255);
    wait_ticks(0, 1, 20);
`ifdef PROG_COUNTER_SATURATE_EN
    check("tick18_cout", cout_a, 255);
`else
    check("tick18_cout", cout_a, 14);
`endif
    wait_ticks(0, 1, 20);
`ifdef PROG_COUNTER_SATURATE_EN
    check("tick19_cout", cout_a, 255);
`else
    check("tick19_cout", cout_a, 29);
`endif

    // DIV_HALF=5 instance over 20 cycles: two full periods.
    highs     = 0;
    rises     = 0;
    updates   = 0;
    unaligned = 0;
    prev_co   = co_b;
    prev_cout = cout_b;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #2;
      if (co_b) highs++;
      if (co_b && !prev_co) rises++;
      if (cout_b != prev_cout) begin
        updates++;
        if (!(co_b && !prev_co)) unaligned++;
      end
      prev_co   = co_b;
      prev_cout = cout_b;
    end
    check("div5_high_cycles", highs,     10);
    check("div5_rising_edges", rises,    2);
    check("div5_cout_updates", updates,  2);
    check("div5_update_align", unaligned, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
